// File: rtl/demux1_to_16_reg_if.sv
// Bundle of the producer handshake, the sixteen consumer channels and the
// transfer counter for the registered 1-to-16 demultiplexer.
interface demux1_to_16_reg_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]    in_data;
  logic [3:0]          in_sel;
  logic                in_bcast;
  logic                in_valid;
  logic                in_ready;
  logic [16*WIDTH-1:0] out_data;
  logic [15:0]         out_valid;
  logic [15:0]         out_ack;
  logic [7:0]          accept_cnt;

  // Producer and consumers together: drive requests and acks, observe outputs.
  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ack,
    input  in_ready, out_data, out_valid, accept_cnt
  );

  // The demultiplexer itself.
  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ack,
    output in_ready, out_data, out_valid, accept_cnt
  );
endinterface

// File: rtl/demux1_to_16_reg.sv
// Registered 1-to-16 demultiplexer: one holding register per channel with a
// valid/ack handshake, optional broadcast to all channels, and a count of
// accepted transfers. Only in_ready is combinational.
module demux1_to_16_reg #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  demux1_to_16_reg_if.slave     bus
);
  localparam int NCH = 16;

  logic [WIDTH-1:0] data_q [NCH];
  logic [NCH-1:0]   valid_q;
  logic [7:0]       cnt_q;

  logic [NCH-1:0]   free;
  logic [NCH-1:0]   target;
  logic [NCH-1:0]   load;
  logic             ready;
  logic             accept;

  // Handshake decode: a channel is free when empty or being drained this
  // cycle; a broadcast needs every channel free so all load together.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    free   = '0;
    target = '0;
    ready  = 1'b0;
    accept = 1'b0;
    load   = '0;
    free   = ~valid_q | bus.out_ack;
    target = bus.in_bcast ? {NCH{1'b1}} : (NCH'(1) << bus.in_sel);
    ready  = bus.in_bcast ? (&free) : free[bus.in_sel];
    accept = bus.in_valid & ready;
    load   = accept ? target : '0;
  end

  // Channel valid flags and transfer counter; reset has priority over any
  // simultaneous request or ack.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (load[n])
          valid_q[n] <= 1'b1;
        else if (bus.out_ack[n])
          valid_q[n] <= 1'b0;
      end
      if (accept)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  // Channel data registers: load on accept, otherwise hold the last value.
  // NOTE: the data array is reset (not just the valid flags) because
  // out_data is required to read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++)
        data_q[n] <= '0;
    end else begin
      for (int n = 0; n < NCH; n++)
        if (load[n])
          data_q[n] <= bus.in_data;
    end
  end

  // Pack the channel registers onto the flat output bus.
  always_comb begin
    bus.out_data = '0;
    for (int n = 0; n < NCH; n++)
      bus.out_data[n*WIDTH +: WIDTH] = data_q[n];
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = valid_q;
  assign bus.accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux1_to_16_reg.sv
// Self-checking bench for demux1_to_16_reg: directed scenarios followed by
// randomized traffic, all compared against a behavioural channel model.
module tb_demux1_to_16_reg;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux1_to_16_reg_if #(.WIDTH(WIDTH)) bus ();

  demux1_to_16_reg #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: what each consumer currently holds.
  logic [7:0] m_data  [16];
  bit         m_full  [16];
  int         m_count = 0;
  bit         last_ready;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Could the model take this request right now?
  function automatic bit model_ready(input bit b, input int s, input logic [15:0] a);
    bit ok;
    if (!b) return !m_full[s] || a[s];
    ok = 1'b1;
    for (int n = 0; n < 16; n++)
      if (m_full[n] && !a[n]) ok = 1'b0;
    return ok;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check in_ready,
  // advance the model at the rising edge, check outputs at the next fall.
  task automatic step(input bit r, input bit v, input int s, input bit b,
                      input logic [7:0] d, input logic [15:0] a);
    bit          exp_rdy;
    logic [127:0] exp_vec;
    logic [15:0]  exp_val;
    rst          = r;
    bus.in_valid = v;
    bus.in_sel   = 4'(s);
    bus.in_bcast = b;
    bus.in_data  = d;
    bus.out_ack  = a;
    #1;
    exp_rdy    = model_ready(b, s, a);
    last_ready = exp_rdy;
    check("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
    @(posedge clk);
    if (r) begin
      for (int n = 0; n < 16; n++) begin
        m_data[n] = 8'h00;
        m_full[n] = 1'b0;
      end
      m_count = 0;
    end else begin
      for (int n = 0; n < 16; n++) begin
        if (v && exp_rdy && (b || s == n)) begin
          m_data[n] = d;
          m_full[n] = 1'b1;
        end else if (a[n]) begin
          m_full[n] = 1'b0;
        end
      end
      if (v && exp_rdy) m_count = (m_count + 1) % 256;
    end
    @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      exp_vec[n*8 +: 8] = m_data[n];
      exp_val[n]        = m_full[n];
    end
    check("out_valid", 128'(bus.out_valid), 128'(exp_val));
    check("out_data", bus.out_data, exp_vec);
    check("accept_cnt", 128'(bus.accept_cnt), 128'(m_count));
  endtask

  task automatic idle(input logic [15:0] a);
    step(1'b0, 1'b0, 0, 1'b0, 8'h00, a);
  endtask

  initial begin
    bit          h_v, h_b;
    int          h_s;
    logic [7:0]  h_d;
    logic [15:0] rnd_ack;

    bus.in_valid = 1'b0;
    bus.in_sel   = 4'd0;
    bus.in_bcast = 1'b0;
    bus.in_data  = 8'h00;
    bus.out_ack  = 16'h0000;
    for (int n = 0; n < 16; n++) begin
      m_data[n] = 8'h00;
      m_full[n] = 1'b0;
    end
    // Bring registers out of X before the first checked cycle.
    @(posedge clk);
    @(negedge clk);

    // Reset for two cycles with a request present: in_ready reads 1, nothing accepted.
    step(1'b1, 1'b1, 5, 1'b0, 8'h77, 16'h0000);
    step(1'b1, 1'b0, 0, 1'b0, 8'h00, 16'h0000);
    check("reset_valid", 128'(bus.out_valid), 128'(16'h0000));
    check("reset_cnt", 128'(bus.accept_cnt), 128'd0);

    // Unicast to channel 3.
    step(1'b0, 1'b1, 3, 1'b0, 8'hA5, 16'h0000);
    check("uni_valid", 128'(bus.out_valid), 128'(16'h0008));
    check("uni_ch3", 128'(bus.out_data[3*8 +: 8]), 128'(8'hA5));
    check("uni_cnt", 128'(bus.accept_cnt), 128'd1);

    // Back-pressure on channel 3, then ack releases it in the same cycle.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3, 1'b0, 8'h3C, 16'h0000);
      check("bp_ch3_hold", 128'(bus.out_data[3*8 +: 8]), 128'(8'hA5));
    end
    step(1'b0, 1'b1, 3, 1'b0, 8'h3C, 16'h0008);
    check("bp_ch3_new", 128'(bus.out_data[3*8 +: 8]), 128'(8'h3C));
    check("bp_valid3", 128'(bus.out_valid[3]), 128'(1'b1));

    // Broadcast blocked by un-acked channel 7.
    idle(16'hFFFF);
    step(1'b0, 1'b1, 7, 1'b0, 8'h42, 16'h0000);
    step(1'b0, 1'b1, 2, 1'b1, 8'hFF, 16'h0000);
    check("bc_blocked_valid", 128'(bus.out_valid), 128'(16'h0080));
    step(1'b0, 1'b1, 2, 1'b1, 8'hFF, 16'h0080);
    check("bc_valid", 128'(bus.out_valid), 128'(16'hFFFF));
    check("bc_data", bus.out_data, {16{8'hFF}});
    check("bc_cnt", 128'(bus.accept_cnt), 128'd4);

    // Streaming into channel 0 with continuous ack, starting from reset.
    step(1'b1, 1'b0, 0, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 0, 1'b0, 8'(i), 16'h0001);
    check("stream_cnt", 128'(bus.accept_cnt), 128'd20);
    check("stream_ch0", 128'(bus.out_data[7:0]), 128'(8'd19));

    // 256 accepts wrap the counter back to its starting value.
    idle(16'hFFFF);
    step(1'b1, 1'b0, 0, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 256; i++)
      step(1'b0, 1'b1, int'($urandom_range(0, 15)), 1'b0, 8'($urandom), 16'hFFFF);
    check("wrap_cnt", 128'(bus.accept_cnt), 128'd0);
    idle(16'hFFFF);
    // Stray ack on empty channels: model expects no change.
    idle(16'h5A5A);
    idle(16'hFFFF);

    // Mid-operation reset with a request and acks present.
    step(1'b0, 1'b1, 1, 1'b0, 8'h11, 16'h0000);
    step(1'b0, 1'b1, 9, 1'b0, 8'h99, 16'h0000);
    step(1'b0, 1'b1, 14, 1'b0, 8'hEE, 16'h0000);
    step(1'b1, 1'b1, 4, 1'b0, 8'h44, 16'h0202);
    check("midrst_valid", 128'(bus.out_valid), 128'(16'h0000));
    check("midrst_data", bus.out_data, 128'd0);
    check("midrst_cnt", 128'(bus.accept_cnt), 128'd0);

    // Randomized traffic; the producer holds its request while stalled.
    h_v = 1'b0; h_b = 1'b0; h_s = 0; h_d = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (!(h_v && !last_ready)) begin
        h_v = ($urandom_range(0, 3) != 0);
        h_b = ($urandom_range(0, 7) == 0);
        h_s = int'($urandom_range(0, 15));
        h_d = 8'($urandom);
      end
      rnd_ack = 16'($urandom) & 16'($urandom);
      step(($urandom_range(0, 99) == 0), h_v, h_s, h_b, h_d, rnd_ack);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux1_to_16_reg.md
# demux1_to_16_reg

Registered 1-to-16 demultiplexer with a one-entry holding register per destination and a valid/ack handshake on every output channel. It routes an 8-bit ALU result to one of sixteen consumers, or broadcasts it to all of them, and is the distribution counterpart of the datapath's 16-to-1 operand selector. It sits on the ALU write-back side. Back-pressure from any channel stalls the single upstream producer.

## Interface
- WIDTH, 8, data width of the input and of each channel
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  result to distribute
- in_sel  input  4  destination channel index (0..15)
- in_bcast  input  1  when high, write all 16 channels; in_sel ignored
- in_valid  input  1  producer presents in_data
- in_ready  output  1  block accepts this cycle (combinational)
- out_data  output  16*WIDTH  channel n occupies bits [n*WIDTH +: WIDTH]
- out_valid  output  16  channel n holds unconsumed data
- out_ack  input  16  consumer n takes its data this cycle; ignored when out_valid[n]=0
- accept_cnt  output  8  number of accepted transfers, wraps modulo 256

## Operation
- Channel n is "free" this cycle when out_valid[n]=0 or out_ack[n]=1 (same-cycle drain and refill permitted).
- Unicast (in_bcast=0): in_ready = free[in_sel].
- Broadcast (in_bcast=1): in_ready = AND of free[0..15]. All channels are loaded together or none are.
- Accept = in_valid & in_ready.
- On accept, each targeted channel loads in_data and sets out_valid.
- Channel not targeted and acked: out_valid clears and out_data holds its last value.
- Channel targeted and acked in the same cycle: the new data loads, out_valid stays 1.
- Acking a channel whose out_valid=0 has no effect.
- accept_cnt increments by 1 per accept. A broadcast counts as 1. 255 wraps to 0.
- in_ready is computed from current state and out_ack only. It never depends on in_valid.
- The producer holds in_data, in_sel and in_bcast stable while in_valid=1 and in_ready=0.

## Timing
- Reset, synchronous: out_data=0 on all channels, out_valid=16'h0000, accept_cnt=0.
- in_ready is combinational. With out_valid all 0 during reset, in_ready reads 1 during reset, but no transfer is accepted.
- Latency: data accepted at edge k appears on out_data/out_valid after edge k. One cycle.
- Throughput: one transfer per cycle per channel, sustained when the consumer acks every cycle.
- rst asserted mid-operation discards all held data and clears the counter on that edge. Simultaneous in_valid and out_ack that cycle are ignored.
- No output other than in_ready has a combinational path from any input.

## Test plan
- Reset then unicast: rst for 2 cycles. Send in_data=8'hA5, in_sel=3, in_valid=1. Required next cycle: out_valid=16'h0008, channel 3 = 8'hA5, accept_cnt=1.
- Back-pressure: channel 3 holds 8'hA5 with no ack. Present 8'h3C to sel=3. Required: in_ready=0 and channel 3 stays 8'hA5 for several cycles. Pulse out_ack[3] that cycle. Required: in_ready=1 in the same cycle, and channel 3 = 8'h3C with out_valid[3]=1 on the next cycle.
- Broadcast blocked: channel 7 valid and un-acked; send in_bcast=1, in_data=8'hFF. Required: in_ready=0 and no channel changes. Ack channel 7. Required: all 16 channels = 8'hFF next cycle, out_valid=16'hFFFF, accept_cnt increments by exactly 1.
- Streaming: sel=0 every cycle with data 0..19, out_ack[0]=1 continuously. Required: in_ready=1 throughout, channel 0 follows the data with 1-cycle lag, accept_cnt=20.
- Counter wrap and stray ack: perform 256 accepts. Required: accept_cnt returns to 0. Ack a channel whose out_valid=0. Required: no state change.
- Mid-operation reset: several channels valid. Assert rst together with in_valid=1 and out_ack. Required next cycle: out_valid=0, all channels 0, accept_cnt=0.
